// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: oversampled line conditioning, frame FSM, E0/F0 prefix decoder and event FIFO.
// Optional build macro PS2_TYPEMATIC_FILTER_EN suppresses repeated make events of the held key.
module ps2_rx_fifo #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          ps2_clk,
  input  logic                          ps2_dat,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_break,
  output logic                          ev_ext,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_MAX  = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYC);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic [FW-1:0]          r_filt_cnt;
  logic                   r_filt, r_filt_d;
  logic [TW-1:0]          r_tmo_cnt;
  state_t                 r_state, w_state_nxt;
  logic [2:0]             r_bitcnt, w_bitcnt_nxt;
  logic [7:0]             r_shift, w_shift_nxt, r_byte;
  logic                   r_par, w_par_nxt;
  logic                   r_good, r_err, w_good, w_err;
  logic                   r_ext_pend, r_brk_pend;
  logic [9:0]             r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [AW:0]            r_count;
  logic                   r_ovf;
  logic                   w_clk_s, w_dat, w_fall, w_tmo;
  logic                   w_cand, w_drop, w_push, w_pop, w_full, w_wr;
  logic [9:0]             w_ev;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat   = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = r_filt_d & ~r_filt;
  assign w_tmo   = (r_state != S_IDLE) && (r_tmo_cnt == TMO_MAX);

  // Synchronisers and glitch filter: the filtered level moves only after FILT_LEN differing samples.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_filt     <= 1'b1;
      r_filt_d   <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_dat};
      r_filt_d   <= r_filt;
      if (w_clk_s == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_MAX) begin
        r_filt     <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  // Frame state register plus the datapath it steers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_bitcnt  <= 3'd0;
      r_shift   <= 8'h00;
      r_par     <= 1'b0;
      r_good    <= 1'b0;
      r_err     <= 1'b0;
      r_byte    <= 8'h00;
      r_tmo_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_par    <= w_par_nxt;
      r_good   <= w_good;
      r_err    <= w_err;
      if (w_good) r_byte <= r_shift;
      if (r_state == S_IDLE || w_fall || w_tmo) r_tmo_cnt <= '0;
      else r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Next-state logic: a timeout overrides any fall seen in the same cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_par_nxt    = r_par;
    w_good       = 1'b0;
    w_err        = 1'b0;
    if (w_tmo) begin
      w_state_nxt = S_IDLE;
      w_err       = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE: begin
          if (!w_dat) begin
            w_state_nxt  = S_DATA;
            w_bitcnt_nxt = 3'd0;
          end else begin
            w_err = 1'b1;
          end
        end
        S_DATA: begin
          w_shift_nxt  = {w_dat, r_shift[7:1]};
          w_bitcnt_nxt = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
          else w_state_nxt = S_DATA;
        end
        S_PARITY: begin
          w_par_nxt   = w_dat;
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          if (w_dat && ((^r_shift) ^ r_par)) w_good = 1'b1;
          else w_err = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  assign w_cand = r_good && (r_byte != 8'hE0) && (r_byte != 8'hF0);
  assign w_ev   = {r_ext_pend, r_brk_pend, r_byte};
  assign w_push = w_cand && !w_drop;

  // Prefix flags collect E0/F0 ahead of the key byte; any frame error forgets them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (r_err) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (r_good) begin
      case (r_byte)
        8'hE0:   r_ext_pend <= 1'b1;
        8'hF0:   r_brk_pend <= 1'b1;
        default: begin
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end
      endcase
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       r_held;
  logic [8:0] r_held_key;
  assign w_drop = w_cand && !r_brk_pend && r_held && (r_held_key == {r_ext_pend, r_byte});

  // Remembers the last make key so auto-repeat copies can be swallowed until its release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_held     <= 1'b0;
      r_held_key <= 9'h000;
    end else if (w_push) begin
      if (!r_brk_pend) begin
        r_held     <= 1'b1;
        r_held_key <= {r_ext_pend, r_byte};
      end else if (r_held_key == {r_ext_pend, r_byte}) begin
        r_held <= 1'b0;
      end
    end
  end
`else
  assign w_drop = 1'b0;
`endif

  assign w_full = (r_count == DEPTH_CNT);
  assign w_pop  = (r_count != '0) && ev_ready;
  assign w_wr   = w_push && (!w_full || w_pop);

  // Event FIFO; a full FIFO still accepts a push when the head leaves in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 10'h000;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= w_ev;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_ovf <= w_push && w_full && !w_pop;
    end
  end

  assign ev_valid   = (r_count != '0);
  assign ev_code    = ev_valid ? r_mem[r_rptr][7:0] : 8'h00;
  assign ev_break   = ev_valid & r_mem[r_rptr][8];
  assign ev_ext     = ev_valid & r_mem[r_rptr][9];
  assign fifo_count = r_count;
  assign overflow   = r_ovf;
  assign frame_err  = r_err;

endmodule
